freq_tone_decoder: RTL and testbench

- Receive-side partner of the frequency encoder: measures the period of an incoming square-wave tone and decodes it back to a 4-bit symbol (0..9).
- Result is presented as a symbol with a valid pulse, a lock flag, and a 7-segment pattern for the uo_out display path.
- Sits between a dedicated input pin (tone_in) and the top-level output mux.

---
 rtl/freq_pkg.sv | 36 +++
 rtl/freq_tone_decoder_if.sv | 21 ++
 rtl/freq_edge_sync.sv | 58 +++++
 rtl/freq_tone_decoder.sv | 144 ++++++++++++++
 tb/tb_freq_tone_decoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared tone symbol constants, decoder state type and 7-segment table
package freq_pkg;

  localparam int SYM_W          = 4;
  localparam int SEG_W          = 7;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_BIN_SHIFT  = 6;
  localparam int DEF_SYM_OFFSET = 2;
  localparam int DEF_NUM_SYM    = 10;
  localparam int DEF_LOCK_CNT   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_e;

  // bit0 = segment a .. bit6 = segment g
  localparam logic [SEG_W-1:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [SEG_W-1:0] seg_of(input logic [SYM_W-1:0] s);
    logic [SEG_W-1:0] pat;
    pat = '0;
    if (s < SYM_W'(DEF_NUM_SYM)) pat = SEG_LUT[s];
    return pat;
  endfunction

  // Centre-of-bin period for a symbol, used by the encoder to generate tones.
  function automatic int sym_period(input int s);
    return ((s + DEF_SYM_OFFSET) << DEF_BIN_SHIFT) + (1 << (DEF_BIN_SHIFT - 1));
  endfunction

endpackage

// File: rtl/freq_tone_decoder_if.sv
// rtl/freq_tone_decoder_if.sv - tone input and decoded symbol/display outputs of the tone decoder
interface freq_tone_decoder_if;
  import freq_pkg::*;

  logic             tone_in;
  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic             locked;
  logic [SEG_W-1:0] segments;

  modport master (
    input  tone_in,
    output sym, sym_valid, locked, segments
  );

  modport slave (
    output tone_in,
    input  sym, sym_valid, locked, segments
  );

endinterface

// File: rtl/freq_edge_sync.sv
// rtl/freq_edge_sync.sv - tone_in synchroniser and rise detector; FREQ_DEC_GLITCH_FILTER_EN adds a 3-sample stable filter
module freq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic lvl;

`ifdef FREQ_DEC_GLITCH_FILTER_EN
  logic h1_q, h1_d;
  logic h2_q, h2_d;

  // s3 holds the filtered level; it only follows s2 once three samples agree.
  always_comb begin
    h1_d = s2_q;
    h2_d = h1_q;
    lvl  = ((s2_q == h1_q) && (h1_q == h2_q)) ? s2_q : s3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else begin
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end
`else
  always_comb lvl = s2_q;
`endif

  always_comb begin
    s1_d = tone_in;
    s2_d = s1_q;
    s3_d = lvl;
  end

  assign rise = lvl & ~s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule

// File: rtl/freq_tone_decoder.sv
// rtl/freq_tone_decoder.sv - measures tone period, bins it to a symbol, locks and drives a 7-seg pattern
// Optional build macro: FREQ_DEC_GLITCH_FILTER_EN (glitch filter inside freq_edge_sync).
module freq_tone_decoder
  import freq_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BIN_SHIFT  = DEF_BIN_SHIFT,
  parameter int SYM_OFFSET = DEF_SYM_OFFSET,
  parameter int NUM_SYM    = DEF_NUM_SYM,
  parameter int LOCK_CNT   = DEF_LOCK_CNT
) (
  input logic                 clk,
  input logic                 rst,
  freq_tone_decoder_if.master bus
);

  // One spare bit so a match count re-seeded from LOCKED can still grow past LOCK_CNT.
  localparam int                 MATCH_W    = $clog2(LOCK_CNT + 2);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   BIN_LO     = CNT_W'(SYM_OFFSET);
  localparam logic [CNT_W-1:0]   BIN_HI     = CNT_W'(SYM_OFFSET + NUM_SYM);
  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);

  dec_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SYM_W-1:0]   cand_q, cand_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               sym_valid_q, sym_valid_d;
  logic               locked_q, locked_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  logic               rise;
  logic               timeout;
  logic               in_range;
  logic               same_bin;
  logic [CNT_W-1:0]   bin;
  logic [SYM_W-1:0]   cand_new;

  freq_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .tone_in (bus.tone_in),
    .rise    (rise)
  );

  // cnt_q on a rise cycle is the period just completed.
  always_comb begin
    bin      = cnt_q >> BIN_SHIFT;
    in_range = (bin >= BIN_LO) && (bin < BIN_HI);
    cand_new = SYM_W'(bin - BIN_LO);
    same_bin = in_range && (cand_new == cand_q);
    timeout  = (cnt_q == CNT_MAX);
    if (rise)         cnt_d = CNT_W'(1);
    else if (timeout) cnt_d = cnt_q;
    else              cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          match_d = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          if (same_bin) begin
            match_d = match_q + MATCH_W'(1);
          end else if (in_range) begin
            cand_d  = cand_new;
            match_d = MATCH_W'(1);
          end else begin
            match_d = '0;
          end
          if (match_d >= MATCH_LOCK) state_d = LOCKED;
        end else if (timeout) begin
          state_d = IDLE;
          match_d = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!same_bin) begin
            state_d = MEASURE;
            if (in_range) begin
              cand_d  = cand_new;
              match_d = MATCH_W'(1);
            end else begin
              match_d = '0;
            end
          end
        end else if (timeout) begin
          state_d = IDLE;
          match_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        match_d = '0;
      end
    endcase
  end

  // Lock is only announced on the MEASURE->LOCKED transition; sym holds afterwards.
  always_comb begin
    sym_valid_d = (state_q == MEASURE) && (state_d == LOCKED);
    locked_d    = (state_d == LOCKED);
    sym_d       = sym_valid_d ? cand_d : sym_q;
    seg_d       = locked_q ? seg_of(sym_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      match_q     <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      seg_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      locked_q    <= locked_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.sym       = sym_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.locked    = locked_q;
  assign bus.segments  = seg_q;

endmodule

// File: tb/tb_freq_tone_decoder.sv
// tb/tb_freq_tone_decoder.sv - directed and randomized bench for freq_tone_decoder against a period-history model
`timescale 1ns/1ps
module tb_freq_tone_decoder;

  localparam int CNT_MAX = 65535;
  localparam int BIN_W   = 64;
`ifdef FREQ_DEC_GLITCH_FILTER_EN
  localparam int EXTRA_LAT = 2;
`else
  localparam int EXTRA_LAT = 0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic tone = 1'b0;

  always #5 clk = ~clk;

  freq_tone_decoder_if b0 ();
  freq_tone_decoder_if b1 ();
  assign b0.tone_in = tone;
  assign b1.tone_in = tone;

  freq_tone_decoder dut0 (.clk(clk), .rst(rst), .bus(b0));
  freq_tone_decoder #(.LOCK_CNT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;
  int vcnt [2];
  bit ever [2];

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int need [2] = '{3, 1};

  // Model state: tone samples, cycles since last rise, recent period symbols.
  bit sm1, sm2, sm3, sm4;
`ifdef FREQ_DEC_GLITCH_FILTER_EN
  bit flt;
`endif
  int since;
  bit armed;
  int hist [$];
  bit m_locked [2];
  int m_sym [2];
  bit m_valid [2];
  logic [6:0] m_seg [2];

  function automatic int code_of(input int period);
    int bin;
    bin = period / BIN_W;
    return (bin >= 2 && bin < 12) ? bin - 2 : -1;
  endfunction

  task automatic model_reset();
    sm1 = 0; sm2 = 0; sm3 = 0; sm4 = 0;
`ifdef FREQ_DEC_GLITCH_FILTER_EN
    flt = 0;
`endif
    since = 0;
    armed = 0;
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_locked[i] = 0; m_sym[i] = 0; m_valid[i] = 0; m_seg[i] = 7'h00;
    end
  endtask

  task automatic model_step();
    bit r;
    bit all_eq;
    int code;
    for (int i = 0; i < 2; i++) begin
      m_seg[i]   = m_locked[i] ? seg_tab[m_sym[i]] : 7'h00;
      m_valid[i] = 0;
    end
`ifdef FREQ_DEC_GLITCH_FILTER_EN
    begin
      bit lvl;
      lvl = (sm2 == sm3 && sm3 == sm4) ? sm2 : flt;
      r   = lvl & ~flt;
      flt = lvl;
    end
`else
    r = sm2 & ~sm3;
`endif
    if (r) begin
      if (armed) begin
        code = code_of(since);
        hist.push_back(code);
        if (hist.size() > 4) void'(hist.pop_front());
        for (int i = 0; i < 2; i++) begin
          if (m_locked[i]) begin
            if (code != m_sym[i]) m_locked[i] = 0;
          end else if (code >= 0 && hist.size() >= need[i]) begin
            all_eq = 1;
            for (int k = 0; k < need[i]; k++)
              if (hist[hist.size() - 1 - k] != code) all_eq = 0;
            if (all_eq) begin
              m_locked[i] = 1; m_sym[i] = code; m_valid[i] = 1;
            end
          end
        end
      end
      armed = 1;
      since = 1;
    end else begin
      if (armed && since == CNT_MAX) begin
        armed = 0;
        hist.delete();
        m_locked[0] = 0;
        m_locked[1] = 0;
      end
      if (since < CNT_MAX) since++;
    end
    sm4 = sm3; sm3 = sm2; sm2 = sm1; sm1 = tone;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic cmp(input int i, input logic [3:0] s, input logic v, input logic l, input logic [6:0] g);
    n_checks++;
    if (s !== 4'(m_sym[i]) || v !== m_valid[i] || l !== m_locked[i] || g !== m_seg[i]) begin
      n_err++;
      $display("FAIL model_dut%0d cyc=%0d got sym=%0d valid=%0b locked=%0b seg=%h exp sym=%0d valid=%0b locked=%0b seg=%h",
               i, cyc, s, v, l, g, m_sym[i], m_valid[i], m_locked[i], m_seg[i]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp(0, b0.sym, b0.sym_valid, b0.locked, b0.segments);
    cmp(1, b1.sym, b1.sym_valid, b1.locked, b1.segments);
    if (b0.sym_valid === 1'b1) vcnt[0]++;
    if (b1.sym_valid === 1'b1) vcnt[1]++;
    if (b0.locked === 1'b1) ever[0] = 1;
    if (b1.locked === 1'b1) ever[1] = 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    vcnt[0] = 0; vcnt[1] = 0; ever[0] = 0; ever[1] = 0;
  endtask

  task automatic tone_period(input int per, input int high);
    tone = 1'b1;
    last_rise_cyc = cyc;
    repeat (high) @(negedge clk);
    tone = 1'b0;
    repeat (per - high) @(negedge clk);
  endtask

  // 480-cycle period with a 2-cycle pulse in the middle of the low phase.
  task automatic glitch_period();
    tone = 1'b1; repeat (240) @(negedge clk);
    tone = 1'b0; repeat (100) @(negedge clk);
    tone = 1'b1; repeat (2)   @(negedge clk);
    tone = 1'b0; repeat (138) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int per;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      tone = (i % 3) == 0;
      @(negedge clk);
    end
    chk("reset_sym", b0.sym, 0);
    chk("reset_valid", b0.sym_valid, 0);
    chk("reset_locked", b0.locked, 0);
    chk("reset_segments", b0.segments, 0);
    tone = 1'b0;
    rst  = 1'b0;
    repeat (5) @(negedge clk);

    clear_stats();
    repeat (3) tone_period(480, 240);
    chk("no_valid_before_4_rises", vcnt[0], 0);
    tone_period(480, 240);
    chk("lock_valid_once", vcnt[0], 1);
    chk("lock_sym", b0.sym, 5);
    chk("lock_locked", b0.locked, 1);
    chk("lock_segments", b0.segments, 7'h6D);
    repeat (4) tone_period(480, 240);
    chk("lock_no_more_pulses", vcnt[0], 1);
    chk("lock1_valid_once", vcnt[1], 1);
    chk("lock1_sym", b1.sym, 5);

    n = 0;
    while (b0.locked === 1'b1 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_delay", cyc - last_rise_cyc, 65538 + EXTRA_LAT);
    @(negedge clk);
    chk("timeout_locked", b0.locked, 0);
    chk("timeout_segments", b0.segments, 0);
    chk("timeout_sym_held", b0.sym, 5);

    repeat (4) tone_period(480, 240);
    chk("relock_locked", b0.locked, 1);
    clear_stats();
    tone_period(192, 96);
    chk("change_still_locked", b0.locked, 1);
    tone_period(192, 96);
    chk("change_drop", b0.locked, 0);
    repeat (2) tone_period(192, 96);
    chk("change_locked", b0.locked, 1);
    chk("change_sym", b0.sym, 1);
    chk("change_segments", b0.segments, 7'h06);
    chk("change_valid_once", vcnt[0], 1);
    chk("change1_valid_once", vcnt[1], 1);

    do_reset(3);
    clear_stats();
    repeat (10) tone_period(100, 50);
    chk("bin1_never_locks", ever[0], 0);
    chk("bin1_never_locks_lc1", ever[1], 0);
    repeat (3) begin
      tone_period(480, 240);
      tone_period(416, 208);
    end
    chk("alternating_never_locks", ever[0], 0);

    do_reset(3);
    clear_stats();
    repeat (7) glitch_period();
`ifdef FREQ_DEC_GLITCH_FILTER_EN
    chk("glitch_filtered_locked", b0.locked, 1);
    chk("glitch_filtered_sym", b0.sym, 5);
`else
    chk("glitch_unfiltered_no_lock", ever[0], 0);
`endif

    do_reset(3);
    for (int s = 0; s < 5; s++) begin
      if ($urandom_range(0, 3) == 0) do_reset(2);
      per = $urandom_range(120, 600);
      n   = $urandom_range(1, 4);
      repeat (n) tone_period(per, $urandom_range(per / 4, (3 * per) / 4));
    end
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
